// File: rtl/mapper_mmc1.sv
// MMC1 (iNES mapper 1): serial-loaded bank registers driving PRG/CHR/PRG-RAM
// addressing, chip selects and nametable mirroring.
module mapper_mmc1 #(
    parameter int PRG_ROM_DEPTH = 18,
    parameter int CHR_ROM_DEPTH = 17,
    parameter int PRG_RAM_DEPTH = 13
) (
    input  logic                     clk_cpu,
    input  logic                     rst_n,
    input  logic [14:0]              cpu_addr,
    input  logic [7:0]               cpu_data_i,
    input  logic                     cpu_rw,
    input  logic                     romsel,
    input  logic [13:0]              ppu_addr,
    input  logic                     chr_ram,
    input  logic                     prg_ram,
    input  logic [PRG_ROM_DEPTH-1:0] prg_mask,
    input  logic [CHR_ROM_DEPTH-1:0] chr_mask,
    input  logic [PRG_RAM_DEPTH-1:0] prgram_mask,
    output logic [PRG_ROM_DEPTH-1:0] prg_addr,
    output logic [CHR_ROM_DEPTH-1:0] chr_addr,
    output logic [PRG_RAM_DEPTH-1:0] prgram_addr,
    output logic                     prg_cs,
    output logic                     chr_cs,
    output logic                     prgram_cs,
    output logic                     ciram_ce,
    output logic                     ciram_a10,
    output logic                     irq,
    output logic [7:0]               mapper_reg_o
);

    // Bank index is at least 4 bits so the prg register always fits.
    localparam int IW = (PRG_ROM_DEPTH > 18) ? PRG_ROM_DEPTH - 14 : 4;
    localparam logic [4:0] SR_EMPTY = 5'b10000;

    logic       wr, wr_d;
    logic [4:0] sr, control, chr0, chr1, prg;
    logic [4:0] value;

    assign wr    = romsel && !cpu_rw;
    assign value = {cpu_data_i[0], sr[4:1]};

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            wr_d    <= 1'b0;
            sr      <= SR_EMPTY;
            control <= 5'b01100;
            chr0    <= '0;
            chr1    <= '0;
            prg     <= '0;
        end else begin
            wr_d <= wr;
            if (wr) begin
                if (cpu_data_i[7]) begin
                    sr      <= SR_EMPTY;
                    control <= control | 5'b01100;
                end else if (!wr_d) begin
                    // marker reaching bit 0 means this is the fifth bit
                    if (!sr[0]) begin
                        sr <= value;
                    end else begin
                        sr <= SR_EMPTY;
                        case (cpu_addr[14:13])
                            2'd0:    control <= value;
                            2'd1:    chr0    <= value;
                            2'd2:    chr1    <= value;
                            default: prg     <= value;
                        endcase
                    end
                end
            end
        end
    end

    logic [IW-1:0]    prg_idx;
    logic [IW+13:0]   prg_full;
    logic [16:0]      chr_full;

    always_comb begin
        prg_idx = '0;
        case (control[3:2])
            2'd2:    prg_idx = cpu_addr[14] ? IW'(prg[3:0]) : '0;
            2'd3:    prg_idx = cpu_addr[14] ? '1 : IW'(prg[3:0]);
            default: prg_idx = IW'({prg[3:1], cpu_addr[14]});
        endcase
    end

    assign prg_full = {prg_idx, cpu_addr[13:0]};
    assign prg_addr = prg_mask & PRG_ROM_DEPTH'(prg_full);

    assign chr_full = control[4] ? {(ppu_addr[12] ? chr1 : chr0), ppu_addr[11:0]}
                                 : {chr0[4:1], ppu_addr[12:0]};
    assign chr_addr = chr_mask & CHR_ROM_DEPTH'(chr_full);

    always_comb begin
        ciram_a10 = 1'b0;
        case (control[1:0])
            2'd0:    ciram_a10 = 1'b0;
            2'd1:    ciram_a10 = 1'b1;
            2'd2:    ciram_a10 = ppu_addr[10];
            default: ciram_a10 = ppu_addr[11];
        endcase
    end

    assign ciram_ce     = ppu_addr[13];
    assign chr_cs       = !ppu_addr[13];
    assign prg_cs       = romsel;
    assign prgram_cs    = prg_ram && !romsel && (cpu_addr[14:13] == 2'b11) && !prg[4];
    assign prgram_addr  = prgram_mask & PRG_RAM_DEPTH'(cpu_addr[12:0]);
    assign irq          = 1'b0;
    assign mapper_reg_o = {3'b000, control};

    // CHR RAM addresses exactly like CHR ROM; data bits 6..1 carry nothing.
    logic unused_bits;
    assign unused_bits = chr_ram ^ (^cpu_data_i[6:1]);

endmodule
